led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

LED pattern controller that replaces the free-running counter bit currently wired to the board user LEDs. It sits directly upstream of the `usr_led*` pins. It accepts a display-mode request over a valid/ready handshake and drives `NUM_LED` outputs with an off, blink, chase or breathing pattern. It also exports a 1 ms-class tick strobe for other housekeeping logic in the top level.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `TICK_HZ`, 1000, tick strobe rate; `TICK_DIV = CLK_HZ/TICK_HZ` must be ≥ 2 and an exact integer.
- `STEP_TICKS`, 500, ticks per pattern step (blink half-period, chase step).
- `NUM_LED`, 3, number of LED outputs (≥ 2).

Ports:
- `clk_50m`  in  1  sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `mode_valid`  in  1  mode request valid.
- `mode_data`  in  2  requested mode: 0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE.
- `mode_ready`  out  1  block can accept a request.
- `led`  out  `NUM_LED`  LED drive, 1 = on; bit 0 maps to `usr_led12`.
- `tick`  out  1  one-cycle strobe every `TICK_DIV` clocks.

## Operation
- Reset: `led` = 0, `tick` = 0, `mode_ready` = 1, state RUN, current mode = BLINK, all counters = 0.
- FSM with two states:
  - RUN: `mode_ready` = 1. On `mode_valid & mode_ready`, latch `mode_data` into the current mode and go to SWITCH.
  - SWITCH: lasts exactly one cycle. `mode_ready` = 0. Prescaler, step counter, PWM counter and duty are cleared, and `led` is loaded with the new mode's initial value. Then return to RUN.
- Prescaler counts 0..`TICK_DIV`-1. `tick` is high during the cycle in which the count equals `TICK_DIV`-1.
- Step counter counts ticks 0..`STEP_TICKS`-1. A step event is `tick` with step counter at `STEP_TICKS`-1; the counter wraps to 0 on that event.
- Patterns (initial value, then action on each step event):
  - OFF: `led` = 0; no step action.
  - BLINK: `led` = all 0, then all bits invert.
  - CHASE: `led` = one-hot bit 0, then rotate left, with bit `NUM_LED`-1 wrapping to bit 0.
  - BREATHE: see Configuration.
- A request whose mode equals the current mode still passes through SWITCH and restarts the pattern.
- `mode_valid` during SWITCH is not accepted. The upstream holds it, and it is accepted in the first RUN cycle.
- Counter widths come from `$clog2` of their terminal values. There is no saturating arithmetic; all counters wrap only at their defined terminal values.
- Reset asserted in any state, including SWITCH, overrides everything on that edge.

## Timing
- Request sampled at edge N moves the FSM to SWITCH. The new initial `led` value is visible after edge N+1, and `mode_ready` returns high after edge N+1.
- First step event occurs `TICK_DIV*STEP_TICKS` clocks after SWITCH exit, and every `TICK_DIV*STEP_TICKS` clocks after that.
- All outputs are registered. There is no combinational path from `mode_valid` to `led`; the only such path is to `mode_ready` via state.

## Configuration
- `LED_BREATHE_EN` defined:
  - Mode 3 drives all LEDs from an 8-bit PWM counter that free-runs 0..255 each clock. `led` bit = (pwm_cnt < duty).
  - Duty steps by ±1 per `tick`: it ramps 0→255, reverses at 255, ramps back to 0, and reverses at 0.
  - Initial duty is 0, direction up.
- `LED_BREATHE_EN` undefined:
  - PWM and duty logic are absent.
  - Mode 3 behaves exactly as BLINK.

## Structure
- Shared package `led_pkg`:
  - `led_mode_t` enum (OFF/BLINK/CHASE/BREATHE).
  - `led_state_t` (RUN/SWITCH).
  - `PWM_W = 8` constant.
- One sub-module `tick_gen`, parameterised by `TICK_DIV`, with inputs clk_50m, rst_n and a synchronous clear, and output `tick`.

## Test plan
Bench parameters: `CLK_HZ`=1000, `TICK_HZ`=100 (`TICK_DIV`=10), `STEP_TICKS`=4, `NUM_LED`=3.
- Reset: `rst_n` low for 3 cycles → `led`=000, `tick`=0, `mode_ready`=1. After release, `tick` pulses every 10 clocks and `led`=111 at clock 40, then toggles every 40 clocks.
- Chase: request mode 2 → `mode_ready` low for 1 cycle and `led`=001 the next cycle. Then 010 at +40, 100 at +80, 001 at +120 (wrap).
- Off: request mode 0 → `led`=000 held for 500 clocks and `tick` still pulses.
- Back-to-back: `mode_valid` held high with mode 2 then mode 1 → second request accepted exactly one cycle after `mode_ready` returns. `led` ends at 000 and toggles 40 clocks later.
- Breathe with `LED_BREATHE_EN` → in each 256-clock window, the high count equals the duty in force. Duty reaches 255 after 2550 clocks, then decreases. Without the macro, mode 3 matches the BLINK waveform cycle-for-cycle.
- Reset while chase shows 010 → `led`=000 after that edge, mode BLINK, first toggle 40 clocks after release.

Source files
------------

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED pattern controller.
//   led_mode_t  : display modes carried on mode_data (OFF/BLINK/CHASE/BREATHE)
//   led_state_t : control FSM states (RUN/SWITCH)
//   PWM_W       : width of the breathing PWM counter and duty register
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } led_state_t;

    localparam int PWM_W = 8;

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle strobe every TICK_DIV clocks. The count runs
// 0..TICK_DIV-1 and tick is high in the cycle where the count is TICK_DIV-1.
// tick is a flop loaded from the next count, so it is exactly that decode but
// registered.
// Ports:
//   clk_50m  in   clock
//   rst_n    in   synchronous active-low reset
//   clr      in   synchronous clear of the count (restarts the tick phase)
//   tick     out  one-cycle strobe
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt + 1'b1;
        if (clr || (cnt == CNT_LAST)) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == CNT_LAST);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
// Drives NUM_LED user LEDs with an off / blink / chase / breathing pattern
// selected over a valid/ready handshake, and exports a tick strobe.
//
// Handshake: a request transfers on a rising edge where mode_valid and
// mode_ready are both high; mode_ready is high only in RUN, so a request held
// through the one-cycle SWITCH state is taken in the first RUN cycle after it.
//
// Build option: define LED_BREATHE_EN to get a PWM breathing effect in mode 3;
// without it mode 3 is identical to BLINK and the PWM logic is not built.
//
// Ports:
//   clk_50m     in   clock
//   rst_n       in   synchronous active-low reset
//   mode_valid  in   mode request valid
//   mode_data   in   requested mode (0 OFF, 1 BLINK, 2 CHASE, 3 BREATHE)
//   mode_ready  out  request can be accepted (high in RUN)
//   led         out  LED drive, 1 = on, bit 0 = usr_led12
//   tick        out  one-cycle strobe every CLK_HZ/TICK_HZ clocks
// -----------------------------------------------------------------------------
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int STEP_TICKS = 500,
    parameter int NUM_LED    = 3
) (
    input  logic               clk_50m,
    input  logic               rst_n,
    input  logic               mode_valid,
    input  logic [1:0]         mode_data,
    output logic               mode_ready,
    output logic [NUM_LED-1:0] led,
    output logic               tick
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int STEP_W   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

    led_state_t        state;
    led_state_t        state_next;
    led_mode_t         cur_mode;
    logic              accept;
    logic              switching;
    logic [STEP_W-1:0] step_cnt;
    logic              step_evt;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mode_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_RUN: begin
                mode_ready = 1'b1;
                if (mode_valid) begin
                    accept     = 1'b1;
                    state_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign switching = (state == ST_SWITCH);

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            cur_mode <= MODE_BLINK;
        end else if (accept) begin
            cur_mode <= led_mode_t'(mode_data);
        end
    end

    // ---------------- timebase ----------------
    // Clearing during SWITCH aligns the tick phase with the new pattern, so
    // the first step lands exactly TICK_DIV*STEP_TICKS clocks after SWITCH.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .clr     (switching),
        .tick    (tick)
    );

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (switching) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

    // Steps act only in RUN; during SWITCH the LEDs hold until the reload.
    assign step_evt = tick && (step_cnt == STEP_LAST) && !switching;

    // ---------------- breathing PWM ----------------
`ifdef LED_BREATHE_EN
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty;
    logic             dir_up;
    logic             pwm_on;

    // Duty walks a triangle 0..255..0 one count per tick.
    always_ff @(posedge clk_50m) begin
        if (!rst_n || switching) begin
            pwm_cnt <= '0;
            duty    <= '0;
            dir_up  <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                if (dir_up) begin
                    if (duty == '1) begin
                        duty   <= duty - 1'b1;
                        dir_up <= 1'b0;
                    end else begin
                        duty <= duty + 1'b1;
                    end
                end else begin
                    if (duty == '0) begin
                        duty   <= duty + 1'b1;
                        dir_up <= 1'b1;
                    end else begin
                        duty <= duty - 1'b1;
                    end
                end
            end
        end
    end

    assign pwm_on = (pwm_cnt < duty);
`endif

    // ---------------- LED register ----------------
    function automatic logic [NUM_LED-1:0] init_pattern(input led_mode_t m);
        logic [NUM_LED-1:0] p;
        p = '0;
        if (m == MODE_CHASE) begin
            p[0] = 1'b1;
        end
        return p;
    endfunction

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            led <= '0;
        end else if (switching) begin
            led <= init_pattern(cur_mode);
        end else begin
            case (cur_mode)
                MODE_OFF: begin
                    led <= '0;
                end
                MODE_BLINK: begin
                    if (step_evt) led <= ~led;
                end
                MODE_CHASE: begin
                    if (step_evt) led <= {led[NUM_LED-2:0], led[NUM_LED-1]};
                end
                MODE_BREATHE: begin
`ifdef LED_BREATHE_EN
                    led <= {NUM_LED{pwm_on}};
`else
                    if (step_evt) led <= ~led;
`endif
                end
                default: begin
                    led <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
// Bench for led_pattern_ctrl at CLK_HZ=1000, TICK_HZ=100 (10-clock tick),
// STEP_TICKS=4 (40-clock step), NUM_LED=3. Honours LED_BREATHE_EN.
// A reference model, phrased as "cycles since the pattern (re)started", is
// compared against the outputs on every falling edge; on top of that a vector
// table and hand-written sequences check the named corner cases.
// -----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_valid = 1'b0;
    logic [1:0] mode_data = 2'd0;
    logic       mode_ready;
    logic [2:0] led;
    logic       tick;

    always #5 clk_50m = ~clk_50m;

    led_pattern_ctrl #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .STEP_TICKS (4),
        .NUM_LED    (3)
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .mode_valid (mode_valid),
        .mode_data  (mode_data),
        .mode_ready (mode_ready),
        .led        (led),
        .tick       (tick)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_j counts clocks since the last reset or SWITCH exit; every output is a
    // closed-form function of (mode, m_j).
    int         m_j = 0;
    int         m_mode = 1;
    bit         m_sw = 1'b0;
    logic [2:0] m_hold = 3'b000;
    bit         chk_en = 1'b0;

    function automatic int tri_duty(input int k);
        int m;
        m = k % 510;
        return (m <= 255) ? m : 510 - m;
    endfunction

    function automatic logic [2:0] pattern(input int mode, input int j);
        logic [2:0] one;
        one = 3'b001;
        case (mode)
            0: return 3'b000;
            2: return one << ((j / 40) % 3);
            3: begin
`ifdef LED_BREATHE_EN
                return (j >= 1 && ((j - 1) % 256) < tri_duty((j - 1) / 10)) ? 3'b111 : 3'b000;
`else
                return ((j / 40) % 2 == 1) ? 3'b111 : 3'b000;
`endif
            end
            default: return ((j / 40) % 2 == 1) ? 3'b111 : 3'b000;
        endcase
    endfunction

    always @(posedge clk_50m) begin
        if (!rst_n) begin
            m_j    <= 0;
            m_mode <= 1;
            m_sw   <= 1'b0;
            m_hold <= 3'b000;
        end else if (m_sw) begin
            m_sw <= 1'b0;
            m_j  <= 0;
        end else begin
            m_j <= m_j + 1;
            if (mode_valid) begin
                m_sw   <= 1'b1;
                m_mode <= int'(mode_data);
                m_hold <= pattern(m_mode, m_j + 1);
            end
        end
    end

    always @(negedge clk_50m) begin
        if (chk_en) begin
            check("model_led", led, m_sw ? m_hold : pattern(m_mode, m_j));
            check("model_tick", tick, (m_j % 10 == 9));
            check("model_ready", mode_ready, !m_sw);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge while in RUN; returns at the falling edge just
    // after SWITCH has exited (pattern age 0).
    task automatic do_req(input logic [1:0] m);
        int n;
        mode_valid = 1'b1;
        mode_data  = m;
        @(negedge clk_50m);
        mode_valid = 1'b0;
        check("req_ready_low", mode_ready, 1'b0);
        n = 0;
        while (mode_ready !== 1'b1 && n < 5) begin
            @(negedge clk_50m);
            n++;
        end
        check("req_ready_back", n, 1);
    endtask

    task automatic cycles_until_all_on(output int n);
        n = 0;
        while (led !== 3'b111 && n < 200) begin
            @(negedge clk_50m);
            n++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [1:0] mode;
        int         dly;
        logic [2:0] exp_led;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int n;
        int nt;
        int bad;

        vecs[0]  = '{"chase_init",   2'd2, 0,   3'b001};
        vecs[1]  = '{"chase_39",     2'd2, 39,  3'b001};
        vecs[2]  = '{"chase_40",     2'd2, 40,  3'b010};
        vecs[3]  = '{"chase_80",     2'd2, 80,  3'b100};
        vecs[4]  = '{"chase_wrap",   2'd2, 120, 3'b001};
        vecs[5]  = '{"off_init",     2'd0, 0,   3'b000};
        vecs[6]  = '{"off_40",       2'd0, 40,  3'b000};
        vecs[7]  = '{"blink_init",   2'd1, 0,   3'b000};
        vecs[8]  = '{"blink_39",     2'd1, 39,  3'b000};
        vecs[9]  = '{"blink_40",     2'd1, 40,  3'b111};
        vecs[10] = '{"blink_80",     2'd1, 80,  3'b000};
`ifdef LED_BREATHE_EN
        vecs[11] = '{"breathe_40",   2'd3, 40,  3'b000};
        vecs[12] = '{"breathe_261",  2'd3, 261, 3'b111};
`else
        vecs[11] = '{"breathe_40",   2'd3, 40,  3'b111};
        vecs[12] = '{"breathe_80",   2'd3, 80,  3'b000};
`endif

        // reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50m);
        check("rst_led", led, 3'b000);
        check("rst_tick", tick, 1'b0);
        check("rst_ready", mode_ready, 1'b1);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        cycles_until_all_on(n);
        check("rst_first_toggle", n, 40);
        nt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_50m);
            nt += int'(tick);
        end
        check("tick_rate", nt, 10);

        // table
        for (int v = 0; v < 13; v++) begin
            do_req(vecs[v].mode);
            repeat (vecs[v].dly) @(negedge clk_50m);
            check(vecs[v].name, led, vecs[v].exp_led);
        end

        // off holds for 500 clocks while tick keeps running
        do_req(2'd0);
        nt  = 0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_50m);
            nt += int'(tick);
            if (led !== 3'b000) bad++;
        end
        check("off_led_held", bad, 0);
        check("off_ticks", nt, 50);

        // back-to-back: valid held, second request taken in first RUN cycle
        mode_valid = 1'b1;
        mode_data  = 2'd2;
        @(negedge clk_50m);
        check("b2b_ready_low1", mode_ready, 1'b0);
        mode_data = 2'd1;
        @(negedge clk_50m);
        check("b2b_ready_high", mode_ready, 1'b1);
        check("b2b_chase_led", led, 3'b001);
        @(negedge clk_50m);
        mode_valid = 1'b0;
        check("b2b_ready_low2", mode_ready, 1'b0);
        @(negedge clk_50m);
        check("b2b_blink_led", led, 3'b000);
        repeat (39) @(negedge clk_50m);
        check("b2b_39", led, 3'b000);
        @(negedge clk_50m);
        check("b2b_40", led, 3'b111);

        // reset while chase shows 010
        do_req(2'd2);
        repeat (40) @(negedge clk_50m);
        check("rc_pre", led, 3'b010);
        rst_n = 1'b0;
        @(negedge clk_50m);
        check("rc_led", led, 3'b000);
        check("rc_ready", mode_ready, 1'b1);
        rst_n = 1'b1;
        cycles_until_all_on(n);
        check("rc_first_toggle", n, 40);

        // mode 3 long run against the model (covers the duty turnaround)
        do_req(2'd3);
`ifdef LED_BREATHE_EN
        repeat (6000) @(negedge clk_50m);
`else
        repeat (300) @(negedge clk_50m);
`endif

        // random requests and occasional resets
        for (int i = 0; i < 4000; i++) begin
            mode_valid = ($urandom_range(0, 99) < 4);
            mode_data  = 2'($urandom_range(0, 3));
            rst_n      = ($urandom_range(0, 999) != 0);
            @(negedge clk_50m);
        end
        mode_valid = 1'b0;
        rst_n      = 1'b1;
        repeat (20) @(negedge clk_50m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
